relu_grad: RTL and testbench

Backward-pass companion to the forward ReLU activation stage.
- During the forward pass it snoops each pre-activation sum and records a 1-bit derivative mask (1 when sign bit is 0, i.e. x >= 0).
- During the backward pass it consumes incoming gradients in the same order and gates each one with its recorded mask.
- It sits between the loss/upstream gradient path and the weight-update logic of the neuron.

---
 rtl/relu_grad_pkg.sv | 13 +
 rtl/relu_grad_if.sv | 25 ++
 rtl/relu_mask_fifo.sv | 62 ++++++
 rtl/relu_grad.sv | 85 ++++++++
 tb/tb_relu_grad.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/relu_grad_pkg.sv
// relu_grad shared types: activation width, mask type, mask helper.
// Optional leaky gating is selected with the RELU_GRAD_LEAKY_EN macro.
package relu_pkg;
    localparam int DATA_W         = 18;
    localparam int LEAK_SHIFT_DEF = 3;

    typedef logic signed [DATA_W-1:0] act_t;
    typedef logic                     mask_t;

    function automatic mask_t relu_mask(input act_t x);
        return ~x[DATA_W-1];
    endfunction
endpackage

// File: rtl/relu_grad_if.sv
// relu_grad streaming bus: forward snoop, upstream gradient, gated output.
// master drives samples/gradients, slave is the relu_grad block.
interface relu_grad_if;
    import relu_pkg::*;

    logic  fwd_valid;
    logic  fwd_ready;
    act_t  fwd_in;
    logic  grad_valid;
    logic  grad_ready;
    act_t  grad_in;
    logic  out_valid;
    logic  out_ready;
    act_t  grad_out;

    modport master (
        output fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
        input  fwd_ready, grad_ready, out_valid, grad_out
    );

    modport slave (
        input  fwd_valid, fwd_in, grad_valid, grad_in, out_ready,
        output fwd_ready, grad_ready, out_valid, grad_out
    );
endinterface

// File: rtl/relu_mask_fifo.sv
// 1-bit derivative mask FIFO, DEPTH deep, full/empty from count only.
// Flush clears pointers and count; reset has priority.
module relu_mask_fifo
    import relu_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  mask_t                    mask_i,
    input  logic                     pop_i,
    output mask_t                    mask_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign mask_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Next pointer and occupancy; pointers wrap naturally.
    always_comb begin
        wr_d  = wr_q + AW'(push_ok);
        rd_d  = rd_q + AW'(pop_ok);
        cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
    end

    // Pointer and count registers, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Mask storage; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (rst_n && !flush_i && push_ok) begin
            mem_q[wr_q] <= mask_i;
        end
    end
endmodule

// File: rtl/relu_grad.sv
// ReLU backward gate: records forward masks, gates gradients in order.
// RELU_GRAD_LEAKY_EN: masked gradients become grad_in >>> LEAK_SHIFT.
module relu_grad
    import relu_pkg::*;
#(
    parameter int DEPTH = 16
`ifdef RELU_GRAD_LEAKY_EN
    ,
    parameter int LEAK_SHIFT = LEAK_SHIFT_DEF
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    relu_grad_if.slave             bus,
    output logic [$clog2(DEPTH):0] mask_count
);
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;
    logic  grad_rdy;
    mask_t mask_rd;
    act_t  gated;

    logic  out_valid_q, out_valid_d;
    act_t  grad_out_q, grad_out_d;

    assign push     = bus.fwd_valid && !full;
    assign grad_rdy = !empty && (!out_valid_q || bus.out_ready);
    assign pop      = bus.grad_valid && grad_rdy;

    assign bus.fwd_ready  = !full;
    assign bus.grad_ready = grad_rdy;
    assign bus.out_valid  = out_valid_q;
    assign bus.grad_out   = grad_out_q;

    relu_mask_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (push),
        .mask_i  (relu_mask(bus.fwd_in)),
        .pop_i   (pop),
        .mask_o  (mask_rd),
        .count_o (mask_count),
        .full_o  (full),
        .empty_o (empty)
    );

    // Gate the gradient with the popped mask.
    always_comb begin
        gated = bus.grad_in;
        if (!mask_rd) begin
`ifdef RELU_GRAD_LEAKY_EN
            gated = bus.grad_in >>> LEAK_SHIFT;
`else
            gated = '0;
`endif
        end
    end

    // Output register: load on accept, drop valid once consumed.
    always_comb begin
        out_valid_d = out_valid_q;
        grad_out_d  = grad_out_q;
        if (pop) begin
            out_valid_d = 1'b1;
            grad_out_d  = gated;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output state, cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            out_valid_q <= 1'b0;
            grad_out_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            grad_out_q  <= grad_out_d;
        end
    end
endmodule

// File: tb/tb_relu_grad.sv
// Self-checking bench for relu_grad: vector table plus scoreboard.
// Leaky expectations apply when RELU_GRAD_LEAKY_EN is defined.
module tb_relu_grad;
    import relu_pkg::*;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic [4:0] mask_count;

    relu_grad_if intf();

    relu_grad #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .bus        (intf.slave),
        .mask_count (mask_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    mask_t m_q[$];
    act_t  exp_q[$];

    typedef struct {
        act_t fwd;
        act_t grad;
        act_t exp;
    } vec_t;

    vec_t tv[4];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic act_t gate(input mask_t m, input act_t g);
`ifdef RELU_GRAD_LEAKY_EN
        return m ? g : (g >>> 3);
`else
        return m ? g : act_t'(0);
`endif
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: model mask FIFO and expected outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            m_q.delete();
            exp_q.delete();
        end else begin
            chk("sb_mask_count", mask_count, m_q.size());
            chk("sb_fwd_ready", intf.fwd_ready, m_q.size() != DEPTH);
            if (intf.out_valid && intf.out_ready) begin
                chk("sb_has_expect", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    chk("sb_grad_out", intf.grad_out, exp_q.pop_front());
            end
            if (intf.grad_valid && intf.grad_ready) begin
                chk("sb_has_mask", m_q.size() > 0, 1);
                if (m_q.size() > 0)
                    exp_q.push_back(gate(m_q.pop_front(), intf.grad_in));
            end
            if (intf.fwd_valid && intf.fwd_ready)
                m_q.push_back(relu_mask(intf.fwd_in));
        end
    end

    initial begin
        intf.fwd_valid  = 1'b0;
        intf.fwd_in     = '0;
        intf.grad_valid = 1'b0;
        intf.grad_in    = '0;
        intf.out_ready  = 1'b1;

        tv[0] = '{act_t'(100),     act_t'(40), act_t'(40)};
        tv[2] = '{act_t'(0),       act_t'(-7), act_t'(-7)};
`ifdef RELU_GRAD_LEAKY_EN
        tv[1] = '{act_t'(-5),      act_t'(40), act_t'(5)};
        tv[3] = '{act_t'(-131072), act_t'(9),  act_t'(1)};
`else
        tv[1] = '{act_t'(-5),      act_t'(40), act_t'(0)};
        tv[3] = '{act_t'(-131072), act_t'(9),  act_t'(0)};
`endif

        // Reset
        cyc();
        cyc();
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", intf.out_valid, 0);
        chk("rst_grad_out", intf.grad_out, 0);
        chk("rst_mask_count", mask_count, 0);
        chk("rst_fwd_ready", intf.fwd_ready, 1);
        chk("rst_grad_ready", intf.grad_ready, 0);

        // 1: table of masks and gradients
        for (int i = 0; i < 4; i++) begin
            intf.fwd_valid = 1'b1;
            intf.fwd_in    = tv[i].fwd;
            cyc();
        end
        intf.fwd_valid = 1'b0;
        #1;
        chk("t1_count4", mask_count, 4);
        for (int i = 0; i < 4; i++) begin
            intf.grad_valid = 1'b1;
            intf.grad_in    = tv[i].grad;
            #1;
            chk("t1_grad_ready", intf.grad_ready, 1);
            cyc();
            chk("t1_out_valid", intf.out_valid, 1);
            chk("t1_grad_out", intf.grad_out, tv[i].exp);
        end
        intf.grad_valid = 1'b0;
        cyc();
        chk("t1_valid_clear", intf.out_valid, 0);
        chk("t1_count0", mask_count, 0);

        // 2: gradient waits for a mask
        intf.grad_valid = 1'b1;
        intf.grad_in    = act_t'(11);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_ready", intf.grad_ready, 0);
            chk("t2_stall_valid", intf.out_valid, 0);
            cyc();
        end
        intf.fwd_valid = 1'b1;
        intf.fwd_in    = act_t'(3);
        #1;
        chk("t2_push_cycle_ready", intf.grad_ready, 0);
        cyc();
        intf.fwd_valid = 1'b0;
        #1;
        chk("t2_ready_after_push", intf.grad_ready, 1);
        cyc();
        chk("t2_out_valid", intf.out_valid, 1);
        chk("t2_grad_out", intf.grad_out, 11);
        intf.grad_valid = 1'b0;
        cyc();

        // 3: fill, hold, push+pop, drain with wrap
        for (int i = 0; i < DEPTH; i++) begin
            intf.fwd_valid = 1'b1;
            intf.fwd_in    = (i % 3 == 0) ? act_t'(-(i + 1)) : act_t'(i);
            cyc();
        end
        intf.fwd_in = act_t'(-20);
        #1;
        chk("t3_full_ready", intf.fwd_ready, 0);
        chk("t3_full_count", mask_count, 16);
        cyc();
        chk("t3_held_count", mask_count, 16);
        intf.grad_valid = 1'b1;
        intf.grad_in    = act_t'(101);
        #1;
        chk("t3_no_bypass", intf.fwd_ready, 0);
        cyc();
        chk("t3_pop_count", mask_count, 15);
        intf.grad_in = act_t'(-102);
        cyc();
        chk("t3_pushpop_count", mask_count, 15);
        intf.fwd_valid = 1'b0;
        for (int k = 0; k < 40 && mask_count != 0; k++) begin
            intf.grad_in = (k % 2 == 1) ? act_t'(-(200 + k)) : act_t'(200 + k);
            cyc();
        end
        chk("t3_drained", mask_count, 0);
        intf.grad_valid = 1'b0;
        cyc();
        chk("t3_valid_clear", intf.out_valid, 0);

        // 4: output backpressure
        intf.out_ready = 1'b0;
        intf.fwd_valid = 1'b1;
        intf.fwd_in    = act_t'(1);
        cyc();
        intf.fwd_in = act_t'(2);
        cyc();
        intf.fwd_valid  = 1'b0;
        intf.grad_valid = 1'b1;
        intf.grad_in    = act_t'(25);
        cyc();
        intf.grad_in = act_t'(30);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t4_hold_valid", intf.out_valid, 1);
            chk("t4_hold_data", intf.grad_out, 25);
            chk("t4_hold_ready", intf.grad_ready, 0);
            cyc();
        end
        intf.out_ready = 1'b1;
        #1;
        chk("t4_release_ready", intf.grad_ready, 1);
        cyc();
        chk("t4_next_valid", intf.out_valid, 1);
        chk("t4_next_data", intf.grad_out, 30);
        intf.grad_valid = 1'b0;
        cyc();
        chk("t4_valid_clear", intf.out_valid, 0);

        // 5: flush then reset mid-transfer
        for (int i = 0; i < 5; i++) begin
            intf.fwd_valid = 1'b1;
            intf.fwd_in    = act_t'((i % 2 == 1) ? -i : i);
            cyc();
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        intf.fwd_valid = 1'b0;
        #1;
        chk("t5_flush_count", mask_count, 0);
        chk("t5_flush_valid", intf.out_valid, 0);
        chk("t5_flush_data", intf.grad_out, 0);
        intf.fwd_valid = 1'b1;
        intf.fwd_in    = act_t'(4);
        cyc();
        intf.fwd_in = act_t'(5);
        cyc();
        intf.fwd_valid  = 1'b0;
        intf.out_ready  = 1'b0;
        intf.grad_valid = 1'b1;
        intf.grad_in    = act_t'(-9);
        cyc();
        chk("t5_pre_rst_valid", intf.out_valid, 1);
        chk("t5_pre_rst_data", intf.grad_out, -9);
        rst_n = 1'b0;
        cyc();
        chk("t5_rst_count", mask_count, 0);
        chk("t5_rst_valid", intf.out_valid, 0);
        chk("t5_rst_data", intf.grad_out, 0);
        rst_n           = 1'b1;
        intf.grad_valid = 1'b0;
        intf.out_ready  = 1'b1;
        cyc();

`ifdef RELU_GRAD_LEAKY_EN
        // 6: leaky slope on masked-off gradients
        for (int i = 0; i < 3; i++) begin
            intf.fwd_valid = 1'b1;
            intf.fwd_in    = act_t'(-1);
            cyc();
        end
        intf.fwd_valid  = 1'b0;
        intf.grad_valid = 1'b1;
        intf.grad_in    = act_t'(-64);
        cyc();
        chk("t6_leak_neg64", intf.grad_out, -8);
        intf.grad_in = act_t'(7);
        cyc();
        chk("t6_leak_7", intf.grad_out, 0);
        intf.grad_in = act_t'(-1);
        cyc();
        chk("t6_leak_neg1", intf.grad_out, -1);
        intf.grad_valid = 1'b0;
        cyc();
`endif

        cyc();
        cyc();
        chk("sb_all_consumed", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
